// File: rtl/riscv_pkg.sv
// Shared register-file widths and the writeback request payload.
package riscv_pkg;

    localparam int unsigned XLEN          = 32;
    localparam int unsigned REG_ADDR_W    = 5;
    localparam int unsigned NUM_REGS      = 32;
    localparam int unsigned WB_FIFO_DEPTH = 2;
    localparam int unsigned WB_CNT_W      = 2;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;

endpackage

// File: rtl/wb_skid_fifo.sv
// Two-entry queue holding ALU results until the writeback port is granted.
module wb_skid_fifo
    import riscv_pkg::*;
#(
    parameter type entry_t = wb_req_t
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                push,
    input  entry_t              push_data,
    input  logic                pop,
    output logic [WB_CNT_W-1:0] count,
    output entry_t              head
);

    entry_t              mem_q [WB_FIFO_DEPTH];
    entry_t              mem_d [WB_FIFO_DEPTH];
    logic                wr_ptr_q;
    logic                wr_ptr_d;
    logic                rd_ptr_q;
    logic                rd_ptr_d;
    logic [WB_CNT_W-1:0] count_q;
    logic [WB_CNT_W-1:0] count_d;
    logic                do_push;
    logic                do_pop;

    // Next-state: guarded push/pop, 1-bit pointers wrap naturally.
    always_comb begin
        do_push  = push && (count_q != WB_CNT_W'(WB_FIFO_DEPTH));
        do_pop   = pop && (count_q != '0);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + WB_CNT_W'(1);
            2'b01:   count_d = count_q - WB_CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers; reset drops every queued entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(WB_FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/rf_writeback.sv
// Register-file writeback: ALU/LSU arbitration, write port and busy scoreboard.
module rf_writeback
    import riscv_pkg::*;
#(
    parameter int unsigned N = XLEN
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  iss_valid,
    input  logic [REG_ADDR_W-1:0] iss_rd,
    input  logic [REG_ADDR_W-1:0] iss_rs1,
    input  logic [REG_ADDR_W-1:0] iss_rs2,
    output logic                  iss_stall,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [N-1:0]          alu_data,
    output logic                  alu_ready,
    input  logic                  lsu_valid,
    input  logic [REG_ADDR_W-1:0] lsu_rd,
    input  logic [N-1:0]          lsu_data,
    output logic                  lsu_ready,
    output logic                  wb_en,
    output logic [REG_ADDR_W-1:0] wb_addr,
    output logic [N-1:0]          wb_data,
    output logic [NUM_REGS-1:0]   busy
);

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [N-1:0]          data;
    } req_t;

    logic [WB_CNT_W-1:0]   fifo_count;
    req_t                  fifo_head;
    req_t                  alu_req;
    req_t                  sel;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  grant_lsu;
    logic                  granted;
    logic                  fifo_has_room;

    logic                  wb_en_q;
    logic                  wb_en_d;
    logic [REG_ADDR_W-1:0] wb_addr_q;
    logic [REG_ADDR_W-1:0] wb_addr_d;
    logic [N-1:0]          wb_data_q;
    logic [N-1:0]          wb_data_d;
    logic [NUM_REGS-1:0]   busy_q;
    logic [NUM_REGS-1:0]   busy_d;

    assign alu_req = '{rd: alu_rd, data: alu_data};

    wb_skid_fifo #(
        .entry_t (req_t)
    ) u_alu_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (alu_req),
        .pop       (fifo_pop),
        .count     (fifo_count),
        .head      (fifo_head)
    );

    // Handshake readies and issue hazard check, all forced low in reset.
    always_comb begin
        fifo_has_room = fifo_count < WB_CNT_W'(WB_FIFO_DEPTH);
        alu_ready     = 1'b0;
        lsu_ready     = 1'b0;
        iss_stall     = 1'b0;
        if (!reset) begin
            alu_ready = fifo_has_room;
            lsu_ready = fifo_has_room;
            iss_stall = iss_valid & (busy_q[iss_rs1] | busy_q[iss_rs2] | busy_q[iss_rd]);
        end
    end

    // Arbitration: a full queue drains first, otherwise LSU beats a queued ALU result.
    always_comb begin
        grant_lsu = lsu_valid & lsu_ready;
        fifo_pop  = (fifo_count != '0) & ~grant_lsu;
        fifo_push = alu_valid & alu_ready;
        granted   = grant_lsu | fifo_pop;
        sel       = fifo_head;
        if (grant_lsu) begin
            sel.rd   = lsu_rd;
            sel.data = lsu_data;
        end
    end

    // Write-port next state; x0 results are consumed without a write strobe.
    always_comb begin
        wb_en_d   = granted && (sel.rd != '0);
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        if (granted) begin
            wb_addr_d = sel.rd;
            wb_data_d = sel.data;
        end
    end

    // Scoreboard next state: clear on presented write, then set on accepted issue.
    always_comb begin
        busy_d = busy_q;
        if (wb_en_q) begin
            busy_d[wb_addr_q] = 1'b0;
        end
        if (iss_valid && !iss_stall && (iss_rd != '0)) begin
            busy_d[iss_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Output and scoreboard registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_en_q   <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
            busy_q    <= '0;
        end else begin
            wb_en_q   <= wb_en_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
            busy_q    <= busy_d;
        end
    end

    assign wb_en   = wb_en_q;
    assign wb_addr = wb_addr_q;
    assign wb_data = wb_data_q;
    assign busy    = busy_q;

endmodule

// File: doc/rf_writeback.md
RF_WRITEBACK -- requirements
Module: rf_writeback

Interface
REQ-001 Parameter: N, default 32, data width of every result and write-port data bus.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Ports: iss_valid input 1, iss_rd input 5, iss_rs1 input 5, iss_rs2 input 5; issue-stage request to claim rd.
REQ-005 Port: iss_stall  output  1  combinational; issue must hold while high.
REQ-006 Ports: alu_valid input 1, alu_rd input 5, alu_data input N, alu_ready output 1; ALU result handshake.
REQ-007 Ports: lsu_valid input 1, lsu_rd input 5, lsu_data input N, lsu_ready output 1; load-result handshake.
REQ-008 Ports: wb_en output 1, wb_addr output 5, wb_data output N; registered write port driving the register file.
REQ-009 Port: busy  output  32  scoreboard, bit i high while register i has an outstanding producer.

Function
REQ-010 A transfer occurs on a source when its valid and ready are both high at a rising clk edge.
REQ-011 ALU results pass through a 2-entry FIFO; alu_ready = (fifo_count < 2), with no full-state bypass.
REQ-012 Grant rule each cycle: if fifo_count == 2, the FIFO head wins; else if lsu_valid, LSU wins; else if the FIFO is non-empty, the FIFO head wins; else no grant.
REQ-013 lsu_ready = (fifo_count < 2), combinational; the LSU never waits behind fewer than 2 queued ALU results.
REQ-014 FIFO push and pop in the same cycle are allowed when 0 < count < 2; count is unchanged.
REQ-015 An ALU result pushed into an empty FIFO is not poppable until the following cycle; minimum ALU latency is 2 cycles from transfer to wb_en.
REQ-016 LSU latency is 1 cycle: the transfer edge loads wb_en/wb_addr/wb_data.
REQ-017 A granted result with rd == 0 is consumed, but wb_en stays 0 for that slot.
REQ-018 wb_en is high for exactly one cycle per granted result with rd != 0; it is 0 in cycles with no grant.
REQ-019 iss_stall = iss_valid & (busy[iss_rs1] | busy[iss_rs2] | busy[iss_rd]).
REQ-020 An issue with iss_valid=1, iss_stall=0 and iss_rd != 0 sets busy[iss_rd] at that edge.
REQ-021 busy[wb_addr] clears at the edge where wb_en=1 is presented, so it is low in the cycle after the register file write.
REQ-022 A set and a clear of the same index at the same edge: set wins.
REQ-023 busy[0] is constant 0.
REQ-024 FIFO pointers are 1 bit and wrap modulo 2; count is 2 bits, range 0..2.

Reset
REQ-025 While reset is high, state is cleared asynchronously: busy=0, fifo_count=0, pointers=0, wb_en=0, wb_addr=0, wb_data=0.
REQ-026 Outputs are 0 during reset: alu_ready=0, lsu_ready=0, iss_stall=0.
REQ-027 Reset asserted mid-operation discards queued ALU results and all pending busy bits; no write is emitted for them.
REQ-028 The first transfer can occur at the first rising edge after reset deasserts.

Structure
REQ-029 Shared package riscv_pkg holds XLEN=32, REG_ADDR_W=5, NUM_REGS=32 and typedef wb_req_t {rd[4:0], data[XLEN-1:0]}.
REQ-030 The 2-entry ALU queue is sub-module wb_skid_fifo (push/pop/count/head); arbitration, scoreboard and output registers live in rf_writeback.

Verification
REQ-031 Scenario: ALU only, rd=5, data=0xDEADBEEF, transfer at cycle t -> wb_en=1, wb_addr=5, wb_data=0xDEADBEEF at t+2; busy[5] low at t+3.
REQ-032 Scenario: ALU and LSU valid together, FIFO empty (ALU rd=3/0x11, LSU rd=4/0x22) -> LSU written first at t+1, ALU at t+2.
REQ-033 Scenario: lsu_valid held high while 3 ALU results are offered -> FIFO reaches 2, alu_ready=0 and lsu_ready=0, head drains; all 3 ALU writes appear in order.
REQ-034 Scenario: issue rd=0, then an ALU result with rd=0 and data=0x1234 -> busy stays 0, no wb_en pulse, alu_ready unaffected.
REQ-035 Scenario: busy[7]=1 and issue rs1=7 -> iss_stall=1; the same cycle wb_en=1 with wb_addr=7 -> iss_stall=0 the next cycle.
REQ-036 Scenario: reset pulsed with 2 entries queued and busy[9]=1 -> busy=0, no wb_en after reset, and a fresh ALU write (rd=9, data=0xA5) emerges with correct data.
